alsu_param: RTL and testbench

Parametrised arithmetic-logic-shift unit, the successor to the fixed 3-bit ALSU. Operand width is generic and the operation pipeline carries a valid flag. An explicit error state machine drives a timed LED blink on illegal commands. The block sits between the board I/O sampling layer and the display/LED drivers.

---
 rtl/alsu_pkg.sv | 27 ++
 rtl/alsu_err_fsm.sv | 54 +++++
 rtl/alsu_param.sv | 110 +++++++++++
 tb/tb_alsu_param.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alsu_pkg.sv
// Shared types and helpers for the parametrised ALSU: opcode and error-FSM enums
// plus the illegal-command decode used by the datapath.
package alsu_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_XOR   = 3'b001,
        OP_ADD   = 3'b010,
        OP_MUL   = 3'b011,
        OP_SHIFT = 3'b100,
        OP_ROT   = 3'b101
    } opcode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ERROR = 1'b1
    } err_state_e;

    // Reduction flags are only meaningful for AND/XOR; MUL is illegal when not built in.
    function automatic logic is_illegal(input logic [2:0] op, input logic red_any,
                                        input logic mul_en);
        logic arith;
        arith = (op == OP_ADD) || (op == OP_MUL) || (op == OP_SHIFT) || (op == OP_ROT);
        return (op[2:1] == 2'b11) || (red_any && arith) || (!mul_en && (op == OP_MUL));
    endfunction

endpackage

// File: rtl/alsu_err_fsm.sv
// Error indicator FSM: on an illegal-command strobe, err rises and leds blink
// (all ones / all zeros) for BLINK_LEN cycles; a new strobe restarts the blink.
module alsu_err_fsm
    import alsu_pkg::*;
#(
    parameter int LED_W     = 16,
    parameter int BLINK_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             illegal_strobe,
    output logic             err,
    output logic [LED_W-1:0] leds
);

    localparam int CW = (BLINK_LEN > 1) ? $clog2(BLINK_LEN) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(BLINK_LEN - 1);

    err_state_e    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            leds  <= '0;
            err   <= 1'b0;
        end else if (illegal_strobe) begin
            state <= ST_ERROR;
            cnt   <= CNT_INIT;
            leds  <= '1;
            err   <= 1'b1;
        end else begin
            case (state)
                ST_ERROR: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        leds  <= '0;
                        err   <= 1'b0;
                    end else begin
                        cnt  <= cnt - 1'b1;
                        leds <= ~leds;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    leds  <= '0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alsu_param.sv
// Two-stage parametrised ALSU: stage 1 samples a valid command, stage 2 computes out.
// Define ALSU_MUL_EN to build the multiplier; without it opcode 011 is illegal.
module alsu_param
    import alsu_pkg::*;
#(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_W          = 16,
    parameter int    BLINK_LEN      = 8,
    localparam int   OW             = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    input  logic             cin,
    input  logic             serial_in,
    input  logic             red_op_A,
    input  logic             red_op_B,
    input  logic             bypass_A,
    input  logic             bypass_B,
    input  logic             direction,
    output logic [OW-1:0]    out,
    output logic             out_valid,
    output logic             err,
    output logic [LED_W-1:0] leds
);

`ifdef ALSU_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif
    localparam logic PRI_A = (INPUT_PRIORITY == "A");
    localparam logic FA_ON = (FULL_ADDER == "ON");

    logic [WIDTH-1:0] a_r, b_r;
    logic [2:0]       op_r;
    logic             cin_r, sin_r, ra_r, rb_r, ba_r, bb_r, dir_r, v1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= '0; b_r <= '0; op_r <= '0;
            cin_r <= 1'b0; sin_r <= 1'b0; ra_r <= 1'b0; rb_r <= 1'b0;
            ba_r <= 1'b0; bb_r <= 1'b0; dir_r <= 1'b0; v1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                a_r <= A; b_r <= B; op_r <= opcode;
                cin_r <= cin; sin_r <= serial_in; ra_r <= red_op_A; rb_r <= red_op_B;
                ba_r <= bypass_A; bb_r <= bypass_B; dir_r <= direction;
            end
        end
    end

    logic             byp_any, red_any, illegal;
    logic [WIDTH-1:0] byp_opnd, red_opnd;
    logic [OW-1:0]    next_out;

    // When both flags of a pair are set, INPUT_PRIORITY decides the operand.
    assign byp_any  = ba_r | bb_r;
    assign red_any  = ra_r | rb_r;
    assign byp_opnd = (ba_r && (!bb_r || PRI_A)) ? a_r : b_r;
    assign red_opnd = (ra_r && (!rb_r || PRI_A)) ? a_r : b_r;
    assign illegal  = !byp_any && is_illegal(op_r, red_any, MUL_EN);

    always_comb begin
        next_out = '0;
        if (byp_any) begin
            next_out = OW'(byp_opnd);
        end else if (!illegal) begin
            case (op_r)
                OP_AND:   next_out = red_any ? OW'(&red_opnd) : OW'(a_r & b_r);
                OP_XOR:   next_out = red_any ? OW'(^red_opnd) : OW'(a_r ^ b_r);
                OP_ADD:   next_out = OW'(a_r) + OW'(b_r) + OW'(cin_r & FA_ON);
`ifdef ALSU_MUL_EN
                OP_MUL:   next_out = OW'(a_r) * OW'(b_r);
`endif
                OP_SHIFT: next_out = dir_r ? {out[OW-2:0], sin_r} : {sin_r, out[OW-1:1]};
                OP_ROT:   next_out = dir_r ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
                default:  next_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) out <= next_out;
        end
    end

    alsu_err_fsm #(
        .LED_W     (LED_W),
        .BLINK_LEN (BLINK_LEN)
    ) u_err_fsm (
        .clk            (clk),
        .rst            (rst),
        .illegal_strobe (v1 & illegal),
        .err            (err),
        .leds           (leds)
    );

endmodule

// File: tb/tb_alsu_param.sv
// Self-checking bench for alsu_param (WIDTH=3, BLINK_LEN=4); MUL expectations
// follow ALSU_MUL_EN so the same bench covers both builds.
module tb_alsu_param;

    localparam int WIDTH     = 3;
    localparam int OW        = 2 * WIDTH;
    localparam int LED_W     = 16;
    localparam int BLINK_LEN = 4;
`ifdef ALSU_MUL_EN
    localparam logic MUL = 1'b1;
`else
    localparam logic MUL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       opcode;
    logic             cin, serial_in, red_op_a, red_op_b, bypass_a, bypass_b, direction;
    logic [OW-1:0]    out;
    logic             out_valid, err;
    logic [LED_W-1:0] leds;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] m_out;
    int checks = 0;
    int errors = 0;

    alsu_param #(
        .WIDTH(WIDTH), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"),
        .LED_W(LED_W), .BLINK_LEN(BLINK_LEN)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .opcode(opcode),
        .cin(cin), .serial_in(serial_in), .red_op_A(red_op_a), .red_op_B(red_op_b),
        .bypass_A(bypass_a), .bypass_B(bypass_b), .direction(direction),
        .out(out), .out_valid(out_valid), .err(err), .leds(leds)
    );

    always #5 clk = ~clk;

    // Reference model: returns {illegal, next_out}.
    function automatic logic [OW:0] model(input logic [2:0] op, input logic [2:0] ta, tb,
                                          input logic tcin, tsin, tra, trb, tba, tbb, tdir,
                                          input logic [OW-1:0] prev);
        logic [2:0]    s;
        logic [OW-1:0] r;
        logic          ill;
        if (tba || tbb) return {1'b0, 3'b000, (tba ? ta : tb)};
        ill = (op >= 3'd6) || ((tra || trb) && op >= 3'd2) || (!MUL && op == 3'd3);
        if (ill) return {1'b1, 6'd0};
        s = tra ? ta : tb;
        case (op)
            3'd0:    r = (tra || trb) ? {5'd0, &s} : {3'd0, ta & tb};
            3'd1:    r = (tra || trb) ? {5'd0, ^s} : {3'd0, ta ^ tb};
            3'd2:    r = {3'd0, ta} + {3'd0, tb} + {5'd0, tcin};
            3'd3:    r = {3'd0, ta} * {3'd0, tb};
            3'd4:    r = tdir ? {prev[4:0], tsin} : {tsin, prev[5:1]};
            3'd5:    r = tdir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
            default: r = '0;
        endcase
        return {1'b0, r};
    endfunction

    // One clock; then scoreboard any out_valid pulse against the expected queue.
    task automatic tick();
        logic [OW-1:0] e;
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_valid: out_valid=1 out=%0h with no command pending", out);
            end else begin
                e = exp_q.pop_front();
                if (out !== e) begin
                    errors++;
                    $display("FAIL sb_out: got %0h expected %0h", out, e);
                end
            end
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] ta, tb,
                        input logic tcin, tsin, tra, trb, tba, tbb, tdir);
        logic [OW:0] r;
        opcode = op; a = ta; b = tb; cin = tcin; serial_in = tsin;
        red_op_a = tra; red_op_b = trb; bypass_a = tba; bypass_b = tbb; direction = tdir;
        in_valid = 1'b1;
        r = model(op, ta, tb, tcin, tsin, tra, trb, tba, tbb, tdir, m_out);
        m_out = r[OW-1:0];
        exp_q.push_back(r[OW-1:0]);
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; opcode = '0; cin = 1'b0;
        serial_in = 1'b0; red_op_a = 1'b0; red_op_b = 1'b0; bypass_a = 1'b0;
        bypass_b = 1'b0; direction = 1'b0; m_out = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out !== '0 || out_valid !== 1'b0 || err !== 1'b0 || leds !== '0) begin
            errors++;
            $display("FAIL reset_values: out=%0h ov=%b err=%b leds=%h expected all 0",
                     out, out_valid, err, leds);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_arith();
        send(3'd2, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (out_valid !== 1'b1 || out !== 6'd15) begin
            errors++;
            $display("FAIL add_result: out=%0d ov=%b expected 15 ov=1", out, out_valid);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_single_pulse: out_valid=%b expected 0", out_valid);
        end
        send(3'd3, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (out !== (MUL ? 6'd30 : 6'd0) || err !== !MUL) begin
            errors++;
            $display("FAIL mul_result: out=%0d err=%b expected %0d err=%b",
                     out, err, (MUL ? 30 : 0), !MUL);
        end
        idle(BLINK_LEN + 1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL mul_err_clear: err=%b expected 0", err);
        end
    endtask

    task automatic test_reduce_bypass();
        send(3'd1, 3'b110, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(3'd0, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(3'd1, 3'b101, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(3'd7, 3'd2, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (out !== 6'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL bypass_both: out=%0d err=%b expected 2 err=0", out, err);
        end
    endtask

    task automatic test_shift_chain();
        send(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            send(3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        checks++;
        if (out !== 6'b111111) begin
            errors++;
            $display("FAIL shift_fill: out=%b expected 111111", out);
        end
        send(3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (out !== 6'b111111) begin
            errors++;
            $display("FAIL rotate_ones: out=%b expected 111111", out);
        end
        send(3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (out !== 6'b100000) begin
            errors++;
            $display("FAIL rotate_right: out=%b expected 100000", out);
        end
        idle(1);
    endtask

    task automatic test_error_blink();
        logic [LED_W-1:0] exp_l;
        send(3'd7, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < BLINK_LEN; i++) begin
            idle(1);
            exp_l = (i % 2 == 0) ? '1 : '0;
            checks++;
            if (leds !== exp_l || err !== 1'b1) begin
                errors++;
                $display("FAIL blink_%0d: leds=%h err=%b expected %h err=1", i, leds, err, exp_l);
            end
        end
        idle(1);
        checks++;
        if (leds !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL blink_end: leds=%h err=%b expected 0000 err=0", leds, err);
        end
        // Second illegal command lands mid-blink and restarts the pattern.
        send(3'd6, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        send(3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (leds !== '0 || err !== 1'b1) begin
            errors++;
            $display("FAIL restart_pre: leds=%h err=%b expected 0000 err=1", leds, err);
        end
        for (int i = 0; i < BLINK_LEN; i++) begin
            idle(1);
            exp_l = (i % 2 == 0) ? '1 : '0;
            checks++;
            if (leds !== exp_l || err !== 1'b1) begin
                errors++;
                $display("FAIL restart_%0d: leds=%h err=%b expected %h err=1", i, leds, err, exp_l);
            end
        end
        idle(1);
        checks++;
        if (leds !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL restart_end: leds=%h err=%b expected 0000 err=0", leds, err);
        end
    endtask

    task automatic test_gap();
        send(3'd0, 3'd5, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            a = 3'($urandom_range(0, 7)); b = 3'($urandom_range(0, 7));
            opcode = 3'($urandom_range(0, 7)); bypass_a = 1'($urandom_range(0, 1));
            in_valid = 1'b0;
            tick();
            checks++;
            if (out !== 6'd1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold_%0d: out=%0d ov=%b expected 1 ov=0", i, out, out_valid);
            end
        end
        send(3'd1, 3'd5, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)));
        end
        idle(BLINK_LEN + 2);
    endtask

    task automatic test_reset_mid();
        send(3'd7, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        send(3'd2, 3'd3, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        // Command in stage 1 when reset hits is dropped, so it is never queued.
        opcode = 3'd2; a = 3'd1; b = 3'd1; in_valid = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out !== '0 || out_valid !== 1'b0 || err !== 1'b0 || leds !== '0) begin
            errors++;
            $display("FAIL reset_mid: out=%0h ov=%b err=%b leds=%h expected all 0",
                     out, out_valid, err, leds);
        end
        in_valid = 1'b0;
        m_out = '0;
        tick();
        rst = 1'b0;
        idle(2);
        checks++;
        if (out !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush: out=%0h ov=%b expected 0 ov=0", out, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_reduce_bypass();
        test_shift_chain();
        test_error_blink();
        test_gap();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d results never produced, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
